vga_line_fetch: RTL and testbench

Downstream consumer of the VGA timing generator. Takes the generator's `row`/`col`/blank/sync outputs and produces RGB pixels from a 320x240 BGR555 framebuffer in memory, pixel-doubled to 640x480. Each framebuffer line is prefetched over a request/grant/response memory port into a ping-pong line buffer while the previous line is displayed. Timing outputs are delayed so sync and colour stay aligned at the DAC.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_line_fetch_line_buffer.sv | 32 +++
 rtl/vga_line_fetch.sv | 180 ++++++++++++++++++
 tb/tb_vga_line_fetch.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pkg : constants, pixel type and colour expansion (rev 1.0)       |
// +----------------------------------------------------------------------+
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int FB_W     = 320;
   localparam int FB_H     = 240;
   localparam int V_LAST   = 520;
   localparam int PIPE_LAT = 2;

   typedef logic [14:0] bgr555_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } fetch_state_t;

   function automatic logic [7:0] expand5(input logic [4:0] c);
      return {c, c[4:2]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_line_fetch_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | line_buffer : 2 x 320 x 15 ping-pong store, sync read (rev 1.0)      |
// +----------------------------------------------------------------------+
module line_buffer
   import vga_pkg::*;
(
   input  logic       clk,
   input  logic       we,
   input  logic       wsel,
   input  logic [8:0] waddr,
   input  bgr555_t    wdata,
   input  logic       rsel,
   input  logic [8:0] raddr,
   output bgr555_t    rdata
);

   bgr555_t mem_q [2][FB_W];
   bgr555_t rdata_q;

   // read-during-write to the same word returns the old contents
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[wsel][waddr] <= wdata;
      end
      rdata_q <= mem_q[rsel][raddr];
   end

   assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/vga_line_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_line_fetch : prefetches framebuffer lines, drives doubled RGB    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vga_line_fetch
   import vga_pkg::*;
#(
   parameter int                ADDR_W  = 20,
   parameter logic [ADDR_W-1:0] FB_BASE = '0
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic [9:0]        row,
   input  logic [9:0]        col,
   input  logic              h_blank,
   input  logic              v_blank,
   input  logic              HS,
   input  logic              VS,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [15:0]       mem_rdata,
   output logic [7:0]        vga_r,
   output logic [7:0]        vga_g,
   output logic [7:0]        vga_b,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic              vga_blank,
   output logic              underrun
);

   fetch_state_t      state_q, state_d;
   logic [8:0]        x_q, x_d;
   logic [7:0]        line_q, line_d;
   logic              done_q, done_d;
   logic              mem_req_q, mem_req_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              underrun_q, underrun_d;
   logic [9:0]        row_q, row_d;
   logic [1:0]        hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
   logic [23:0]       rgb_q, rgb_d;

   logic              row_chg, trig, late, pending, buf_we;
   logic [7:0]        trig_line;
   bgr555_t           rd_data;
   logic              unused_bits;

   assign unused_bits = &{1'b0, col[0], mem_rdata[15]};

   function automatic logic [ADDR_W-1:0] line_addr(input logic [7:0] l, input logic [8:0] x);
      return FB_BASE + (ADDR_W'(l) << 8) + (ADDR_W'(l) << 6) + ADDR_W'(x);
   endfunction

   line_buffer u_buf (
      .clk   (CLOCK_50),
      .we    (buf_we),
      .wsel  (line_q[0]),
      .waddr (x_q),
      .wdata (mem_rdata[14:0]),
      .rsel  (row[1]),
      .raddr (col[9:1]),
      .rdata (rd_data)
   );

   always_comb begin
      row_chg   = (row != row_q);
      trig      = row_chg && ((row[0] && (row < 10'(V_ACTIVE - 1))) || (row == 10'(V_LAST)));
      trig_line = (row == 10'(V_LAST)) ? 8'd0 : 8'(row[9:1] + 9'd1);
      late      = row_chg && !row[0] && (row < 10'(V_ACTIVE)) && !(done_q && (line_q == row[8:1]));

      state_d    = state_q;
      x_d        = x_q;
      line_d     = line_q;
      done_d     = done_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      underrun_d = underrun_q || late;
      buf_we     = 1'b0;
      pending    = 1'b0;

      if (trig) begin
         line_d     = trig_line;
         x_d        = 9'd0;
         done_d     = 1'b0;
         mem_addr_d = line_addr(trig_line, 9'd0);
         if (state_q != ST_IDLE) begin
            underrun_d = 1'b1;
         end
         // a response still owed to the aborted fetch must be swallowed first
         unique case (state_q)
            ST_REQ:            pending = mem_gnt;
            ST_WAIT, ST_DRAIN: pending = !mem_rvalid;
            default:           pending = 1'b0;
         endcase
         state_d   = pending ? ST_DRAIN : ST_REQ;
         mem_req_d = !pending;
      end else begin
         unique case (state_q)
            ST_REQ: begin
               if (mem_gnt) begin
                  state_d   = ST_WAIT;
                  mem_req_d = 1'b0;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  buf_we = 1'b1;
                  if (x_q == 9'(FB_W - 1)) begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     x_d        = x_q + 9'd1;
                     state_d    = ST_REQ;
                     mem_req_d  = 1'b1;
                     mem_addr_d = line_addr(line_q, x_q + 9'd1);
                  end
               end
            end
            ST_DRAIN: begin
               if (mem_rvalid) begin
                  state_d   = ST_REQ;
                  mem_req_d = 1'b1;
               end
            end
            default: ;
         endcase
      end

      row_d   = row;
      hs_d    = {hs_q[0], HS};
      vs_d    = {vs_q[0], VS};
      blank_d = {blank_q[0], h_blank | v_blank};
      rgb_d   = blank_q[0] ? 24'h0 :
                {expand5(rd_data[4:0]), expand5(rd_data[9:5]), expand5(rd_data[14:10])};
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         x_q        <= '0;
         line_q     <= '0;
         done_q     <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         underrun_q <= 1'b0;
         row_q      <= '0;
         hs_q       <= 2'b11;
         vs_q       <= 2'b11;
         blank_q    <= 2'b11;
         rgb_q      <= '0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         line_q     <= line_d;
         done_q     <= done_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         underrun_q <= underrun_d;
         row_q      <= row_d;
         hs_q       <= hs_d;
         vs_q       <= vs_d;
         blank_q    <= blank_d;
         rgb_q      <= rgb_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign underrun  = underrun_q;
   assign vga_r     = rgb_q[23:16];
   assign vga_g     = rgb_q[15:8];
   assign vga_b     = rgb_q[7:0];
   assign vga_hs    = hs_q[1];
   assign vga_vs    = vs_q[1];
   assign vga_blank = blank_q[1];

endmodule
`default_nettype wire

// File: tb/tb_vga_line_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_line_fetch : directed bench with a latency-configurable memory |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_vga_line_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  row, col;
   logic        h_blank, v_blank, HS, VS;
   logic        mem_req, mem_gnt;
   logic [19:0] mem_addr;
   logic        mem_rvalid = 1'b0;
   logic [15:0] mem_rdata  = 16'h0;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, vga_blank, underrun;

   int tests = 0;
   int fails = 0;

   logic        gnt_en  = 1'b1;
   int          lat_cfg = 1;
   logic        pend     = 1'b0;
   int          pend_cnt = 0;
   logic [19:0] pend_addr = 20'h0;
   int          gnt_total = 0;
   int          rv_total  = 0;
   logic [19:0] gaddr [4096];

   vga_line_fetch #(.ADDR_W(20), .FB_BASE(20'h00000)) dut (
      .CLOCK_50   (clk),
      .reset      (reset),
      .row        (row),
      .col        (col),
      .h_blank    (h_blank),
      .v_blank    (v_blank),
      .HS         (HS),
      .VS         (VS),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .vga_r      (vga_r),
      .vga_g      (vga_g),
      .vga_b      (vga_b),
      .vga_hs     (vga_hs),
      .vga_vs     (vga_vs),
      .vga_blank  (vga_blank),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   // framebuffer contents; bit 15 set so the ignored bit is exercised
   function automatic logic [15:0] fbdata(input logic [19:0] a);
      logic [15:0] v;
      v = {1'b1, a[14:0] ^ 15'h2A5A};
      if (a == 20'h0) v = 16'h7C1F;
      return v;
   endfunction

   assign mem_gnt = mem_req & gnt_en;

   always @(posedge clk) begin
      mem_rvalid <= 1'b0;
      if (pend) begin
         if (pend_cnt <= 1) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= fbdata(pend_addr);
            pend       <= 1'b0;
         end else begin
            pend_cnt <= pend_cnt - 1;
         end
      end
      if (mem_req && mem_gnt) begin
         pend                  <= 1'b1;
         pend_cnt              <= lat_cfg;
         pend_addr             <= mem_addr;
         gaddr[gnt_total[11:0]] <= mem_addr;
         gnt_total             <= gnt_total + 1;
      end
      if (mem_rvalid) rv_total <= rv_total + 1;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_words(input string tag, input int r0, input int n, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         if (rv_total - r0 >= n) break;
         tick();
      end
      chk(tag, (i < budget) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic check_addrs(input string tag, input int g0, input int base);
      int errs;
      errs = 0;
      for (int i = 0; i < 320; i++) begin
         if (gaddr[(g0 + i) & 4095] !== 20'(base + i)) errs++;
      end
      chk(tag, errs, 0);
   endtask

   task automatic line_start(input logic [9:0] r);
      row     = r;
      h_blank = 1'b1;
      v_blank = 1'b0;
      col     = 10'd700;
      tick(3);
   endtask

   // three leftmost framebuffer pixels of a display row, each lasting 4 cycles
   task automatic row_pixels(input string tag, input logic [23:0] p0, input logic [23:0] p1,
                             input logic [23:0] p2);
      logic [23:0] e;
      for (int c = 0; c < 12; c++) begin
         h_blank = 1'b0;
         col     = 10'(c >> 1);
         tick();
         if (c == 0)              e = 24'h0;
         else if (((c - 1) >> 2) == 0) e = p0;
         else if (((c - 1) >> 2) == 1) e = p1;
         else                     e = p2;
         chk(tag, {vga_r, vga_g, vga_b}, e);
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int g0, r0, i;
      int bad;

      reset = 1'b0; row = 10'd0; col = 10'd0;
      h_blank = 1'b1; v_blank = 1'b1; HS = 1'b0; VS = 1'b0;
      tick(3);
      chk("rst_req",   mem_req, 0);
      chk("rst_addr",  mem_addr, 0);
      chk("rst_rgb",   {vga_r, vga_g, vga_b}, 0);
      chk("rst_blank", vga_blank, 1);
      chk("rst_hs",    vga_hs, 1);
      chk("rst_vs",    vga_vs, 1);
      chk("rst_under", underrun, 0);
      HS = 1'b1; VS = 1'b1;
      reset = 1'b1;
      tick(2);

      // line 0 fetched on entry to row 520
      g0 = gnt_total; r0 = rv_total;
      row = 10'd520;
      chk("l0_req_pre", mem_req, 0);
      tick();
      chk("l0_req_rise", mem_req, 1);
      chk("l0_addr0",    mem_addr, 0);
      wait_words("l0_timeout", r0, 320, 1500);
      tick(3);
      chk("l0_idle",  mem_req, 0);
      chk("l0_words", rv_total - r0, 320);
      chk("l0_gnts",  gnt_total - g0, 320);
      check_addrs("l0_addrs", g0, 0);
      chk("l0_under", underrun, 0);

      line_start(10'd0);
      chk("r0_under", underrun, 0);
      row_pixels("r0_pix", 24'hFF00FF, 24'hDE9452, 24'hC69452);

      // row 1 launches line 1 while it shows the same pixels as row 0
      g0 = gnt_total; r0 = rv_total;
      line_start(10'd1);
      row_pixels("r1_pix", 24'hFF00FF, 24'hDE9452, 24'hC69452);
      wait_words("l1_timeout", r0, 320, 1500);
      tick(3);
      chk("l1_words", rv_total - r0, 320);
      check_addrs("l1_addrs", g0, 320);
      chk("l1_under", underrun, 0);

      row = 10'd490; v_blank = 1'b1; h_blank = 1'b0; col = 10'd100; VS = 1'b0;
      tick();
      chk("vs490_d1", vga_vs, 1);
      tick();
      chk("vs490_d2", vga_vs, 0);
      chk("vblank_blank", vga_blank, 1);
      chk("vblank_rgb", {vga_r, vga_g, vga_b}, 0);
      col = 10'd656; h_blank = 1'b1; HS = 1'b0;
      tick();
      chk("hs1312_d1", vga_hs, 1);
      tick();
      chk("hs1312_d2", vga_hs, 0);
      col = 10'd752; HS = 1'b1;
      tick();
      chk("hs1504_d1", vga_hs, 0);
      tick();
      chk("hs1504_d2", vga_hs, 1);
      row = 10'd492; VS = 1'b1;
      tick();
      chk("vs492_d1", vga_vs, 0);
      tick();
      chk("vs492_d2", vga_vs, 1);
      v_blank = 1'b0;

      // grant stall while fetching line 2
      gnt_en = 1'b0;
      g0 = gnt_total; r0 = rv_total;
      row = 10'd3; h_blank = 1'b1;
      tick();
      chk("stall_req",  mem_req, 1);
      chk("stall_addr", mem_addr, 640);
      bad = 0;
      for (i = 0; i < 50; i++) begin
         tick();
         if (mem_req !== 1'b1 || mem_addr !== 20'd640) bad++;
      end
      chk("stall_stable", bad, 0);
      chk("stall_nognt", gnt_total - g0, 0);
      gnt_en = 1'b1;
      wait_words("l2_timeout", r0, 320, 1500);
      tick(3);
      chk("l2_words", rv_total - r0, 320);
      check_addrs("l2_addrs", g0, 640);
      line_start(10'd4);
      chk("r4_under", underrun, 0);
      row_pixels("r4_pix", 24'hD63152, 24'hDE3152, 24'hC63152);

      // slow memory: line 3 cannot finish before row 6
      lat_cfg = 12;
      row = 10'd5;
      tick(100);
      row = 10'd6;
      tick(2);
      chk("slow_under", underrun, 1);
      for (i = 0; i < 40; i++) begin
         if (mem_req) break;
         tick();
      end
      chk("slow_req_seen", (i < 40) ? 32'd1 : 32'd0, 32'd1);
      tick();
      row = 10'd7;
      tick();
      for (i = 0; i < 20; i++) begin
         if (mem_rvalid) break;
         tick();
      end
      chk("abort_rvalid_seen", (i < 20) ? 32'd1 : 32'd0, 32'd1);
      chk("abort_no_req", mem_req, 0);
      tick();
      chk("restart_req",  mem_req, 1);
      chk("restart_addr", mem_addr, 1280);
      chk("restart_under", underrun, 1);

      // reset in the middle of the line 4 fetch
      reset = 1'b0; row = 10'd0; col = 10'd0; h_blank = 1'b0; v_blank = 1'b0;
      tick(3);
      chk("mid_rst_req",   mem_req, 0);
      chk("mid_rst_addr",  mem_addr, 0);
      chk("mid_rst_rgb",   {vga_r, vga_g, vga_b}, 0);
      chk("mid_rst_blank", vga_blank, 1);
      chk("mid_rst_under", underrun, 0);
      reset = 1'b1;
      g0 = gnt_total;
      tick(30);
      chk("post_rst_nognt", gnt_total - g0, 0);
      chk("post_rst_req",   mem_req, 0);
      chk("post_rst_under", underrun, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
